// File: rtl/store_narrow_unit.sv
// Narrows SB/SH/SW register stores onto a 16-bit data-memory write port.
// Words go out as two little-endian halfword beats; misaligned, illegal and stalled stores report st_err.
module store_narrow_unit #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_size,
  output logic              st_busy,
  output logic              st_done,
  output logic              st_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [1:0]        mem_be
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_BEAT0, S_BEAT1, S_RESP_OK, S_RESP_ERR
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [1:0]        size_q;
  logic [7:0]        wait_cnt;
  logic              misalign, hs, timeout;

  assign mem_valid = (state == S_BEAT0) || (state == S_BEAT1);
  assign st_busy   = (state != S_IDLE);
  assign st_done   = (state == S_RESP_OK);
  assign st_err    = (state == S_RESP_ERR);
  assign hs        = mem_valid & mem_ready;
  // Abort on the MAX_WAIT-th stalled cycle so valid is high for exactly MAX_WAIT wait cycles.
  assign timeout   = mem_valid & ~mem_ready & (wait_cnt == WAIT_LAST);

  always_comb begin
    misalign = 1'b0;
    unique case (size_q)
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = addr_q[0];
      SZ_WORD: misalign = |addr_q[1:0];
      default: misalign = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (st_req) state_nx = S_CHECK;
      S_CHECK:    state_nx = misalign ? S_RESP_ERR : S_BEAT0;
      S_BEAT0: begin
        if (hs)           state_nx = (size_q == SZ_WORD) ? S_BEAT1 : S_RESP_OK;
        else if (timeout) state_nx = S_RESP_ERR;
      end
      S_BEAT1: begin
        if (hs)           state_nx = S_RESP_OK;
        else if (timeout) state_nx = S_RESP_ERR;
      end
      S_RESP_OK:  state_nx = S_IDLE;
      S_RESP_ERR: state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      data_q    <= '0;
      size_q    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      wait_cnt  <= '0;
    end else begin
      if (state == S_IDLE && st_req) begin
        addr_q <= st_addr;
        data_q <= st_data;
        size_q <= st_size;
      end
      if (state == S_CHECK && !misalign) begin
        mem_addr <= {addr_q[ADDR_W-1:1], 1'b0};
        wait_cnt <= '0;
        if (size_q == SZ_BYTE) begin
          mem_wdata <= {data_q[7:0], data_q[7:0]};
          mem_be    <= addr_q[0] ? 2'b10 : 2'b01;
        end else begin
          mem_wdata <= data_q[15:0];
          mem_be    <= 2'b11;
        end
      end
      if (mem_valid) begin
        if (hs) wait_cnt <= '0;
        else    wait_cnt <= wait_cnt + 8'd1;
      end
      // Upper half of a word; address wraps naturally at the top of memory.
      if (state == S_BEAT0 && hs && size_q == SZ_WORD) begin
        mem_addr  <= mem_addr + ADDR_W'(2);
        mem_wdata <= data_q[31:16];
        mem_be    <= 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Scoreboard bench for store_narrow_unit: a stimulus process feeds randomized and directed stores,
// a ready responder stalls beats, and a monitor checks every beat and response.
module tb_store_narrow_unit;
  localparam int ADDR_W   = 32;
  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_req = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [1:0]  st_size = '0;
  logic        mem_ready;
  logic        st_busy, st_done, st_err, mem_valid;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;

  store_narrow_unit #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .st_req(st_req), .st_addr(st_addr), .st_data(st_data),
    .st_size(st_size), .st_busy(st_busy), .st_done(st_done), .st_err(st_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } beat_t;

  beat_t exp_beats[$];
  int    exp_resp[$];   // 1 = done, 2 = err
  int    wq[$];         // stall cycles for each beat the DUT will present
  int    checks = 0, errors = 0;
  int    cyc = 0, resp_cyc = 0, vcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the memory should see for one store, given the stall per beat.
  task automatic model(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                       input int w0, input int w1);
    beat_t b;
    int    nb, w;
    if (sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) begin
      exp_resp.push_back(2);
      return;
    end
    nb = (sz == 2'b10) ? 2 : 1;
    for (int i = 0; i < nb; i++) begin
      w = (i == 0) ? w0 : w1;
      wq.push_back(w);
      if (w >= MAX_WAIT) begin
        exp_resp.push_back(2);
        return;
      end
      b.addr  = (a & ~32'd1) + 32'(2 * i);
      b.wdata = (sz == 2'b00) ? {d[7:0], d[7:0]} : ((i == 0) ? d[15:0] : d[31:16]);
      b.be    = (sz == 2'b00) ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
      exp_beats.push_back(b);
    end
    exp_resp.push_back(1);
  endtask

  // Ready responder: holds mem_ready low for the planned number of cycles of each beat.
  int cur_w = 0, cnt = 0;
  bit have_cur = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      have_cur  = 1'b0;
      mem_ready = 1'b0;
    end else begin
      if (have_cur && (mem_ready || !mem_valid)) have_cur = 1'b0;
      if (mem_valid && !have_cur) begin
        check("valid_expected", 64'(wq.size() != 0), 64'd1);
        if (wq.size() != 0) begin
          cur_w    = wq.pop_front();
          have_cur = 1'b1;
          cnt      = 0;
        end
      end
      if (have_cur) begin
        mem_ready = (cnt >= cur_w);
        cnt++;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor
  beat_t prev;
  bit    prev_wait = 1'b0;
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (mem_valid) vcnt++;
      if (prev_wait && mem_valid) check("hold_stable", {mem_addr, mem_wdata, mem_be}, prev);
      prev_wait = mem_valid && !mem_ready;
      prev      = {mem_addr, mem_wdata, mem_be};
      if (mem_valid && mem_ready) begin
        if (exp_beats.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %0h/%0h/%0h expected none", mem_addr, mem_wdata, mem_be);
        end else check("beat", {mem_addr, mem_wdata, mem_be}, exp_beats.pop_front());
      end
      if (st_done || st_err) begin
        check("done_err_excl", 64'(st_done && st_err), 64'd0);
        resp_cyc = cyc;
        if (exp_resp.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: got done=%0b err=%0b expected none", st_done, st_err);
        end else check("resp", st_err ? 64'd2 : 64'd1, 64'(exp_resp.pop_front()));
      end
    end else prev_wait = 1'b0;
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (st_busy && n < 2000);
    if (st_busy) check("idle_timeout", 64'd1, 64'd0);
  endtask

  // Called at a negedge with the unit idle.
  task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                          input int w0, input int w1, input int exp_lat);
    int t0;
    model(sz, a, d, w0, w1);
    st_req = 1'b1; st_size = sz; st_addr = a; st_data = d;
    t0 = cyc;
    @(negedge clk);
    st_req = 1'b0;
    wait_idle();
    if (exp_lat >= 0) check("latency", 64'(resp_cyc - t0), 64'(exp_lat));
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a, d;
    int          w0, w1, lat, v0, r;

    repeat (3) @(negedge clk);
    check("reset_outputs", {st_busy, st_done, st_err, mem_valid, mem_addr, mem_wdata, mem_be}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_store(2'b00, 32'h1001, 32'hAABBCCDD, 0, 0, 3);
    do_store(2'b10, 32'h2000, 32'h12345678, 3, 3, -1);
    do_store(2'b01, 32'h0003, 32'h0000BEEF, 0, 0, 2);
    do_store(2'b10, 32'h0002, 32'h11223344, 0, 0, 2);
    do_store(2'b11, 32'h0040, 32'h55667788, 0, 0, 2);
    check("busy_clear", 64'(st_busy), 64'd0);

    v0 = vcnt;
    do_store(2'b10, 32'h3000, 32'hDEADBEEF, 100, 0, -1);
    check("timeout_valid_cycles", 64'(vcnt - v0), 64'(MAX_WAIT));
    do_store(2'b00, 32'h3002, 32'h00000055, 0, 0, 3);

    // Reset while the second beat of a word is stalled.
    model(2'b10, 32'h4000, 32'hA5A5C3C3, 0, 50);
    st_req = 1'b1; st_size = 2'b10; st_addr = 32'h4000; st_data = 32'hA5A5C3C3;
    @(negedge clk);
    st_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("beat1_active", {mem_valid, mem_addr}, {1'b1, 32'h4002});
    rst_n = 1'b0;
    #1;
    check("reset_mid_beat", {st_busy, st_done, st_err, mem_valid, mem_addr, mem_wdata, mem_be}, 64'd0);
    wq.delete(); exp_beats.delete(); exp_resp.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_store(2'b01, 32'h0010, 32'h0000BEEF, 0, 0, 3);

    // Request held high with new contents while busy; only accepted after busy drops.
    model(2'b10, 32'hFFFFFFFC, 32'hCAFEF00D, 1, 0);
    st_req = 1'b1; st_size = 2'b10; st_addr = 32'hFFFFFFFC; st_data = 32'hCAFEF00D;
    @(negedge clk);
    st_size = 2'b01; st_addr = 32'h0500; st_data = 32'h11112222;
    wait_idle();
    model(2'b01, 32'h0500, 32'h11112222, 0, 0);
    @(negedge clk);
    st_req = 1'b0;
    wait_idle();

    for (int i = 0; i < 150; i++) begin
      r  = int'($urandom_range(0, 7));
      sz = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
      a  = $urandom;
      d  = $urandom;
      if ($urandom_range(0, 9) < 7) a = (sz == 2'b10) ? (a & ~32'd3) : (sz == 2'b01) ? (a & ~32'd1) : a;
      w0 = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4)) : int'($urandom_range(MAX_WAIT - 2, MAX_WAIT + 3));
      w1 = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4)) : int'($urandom_range(MAX_WAIT - 2, MAX_WAIT + 3));
      if (sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) lat = 2;
      else if (w0 == 0 && w1 == 0) lat = (sz == 2'b10) ? 4 : 3;
      else lat = -1;
      do_store(sz, a, d, w0, w1, lat);
    end

    repeat (3) @(negedge clk);
    check("queues_drained", 64'(exp_beats.size() + exp_resp.size() + wq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
